// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor
//   Gshare direction predictor plus a tagged, direct-mapped branch target
//   buffer for the fetch stage. After reset a walker initialises every PHT
//   counter to weakly not-taken and invalidates every BTB entry, one index per
//   cycle. Lookups are answered with one cycle of latency. Global history is
//   shifted speculatively with each prediction and restored from the pipe's
//   snapshot on a mispredict.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ready                 high once the init walk has finished
//   lookup_valid/_stall   lookup request from IF (ignored while stalled)
//   lookup_pc             fetch PC of the control-flow instruction
//   pred_valid            one-cycle pulse per accepted lookup
//   pred_taken            predicted redirect
//   pred_target           predicted target (0 when not taken)
//   pred_ghr              history snapshot used for this prediction
//   upd_*                 resolution from EX/MEM: pc, history snapshot,
//                         outcome, unconditional flag, target, mispredict
module gshare_btb_predictor #(
  parameter int PC_WIDTH     = 16,
  parameter int PHT_IDX_BITS = 8,
  parameter int GHR_BITS     = 8,
  parameter int CTR_BITS     = 2,
  parameter int BTB_IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                ready,
  input  logic                lookup_valid,
  input  logic                lookup_stall,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_uncond,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict
);

  localparam int INIT_BITS = (PHT_IDX_BITS > BTB_IDX_BITS) ? PHT_IDX_BITS : BTB_IDX_BITS;
  localparam int PHT_N     = 1 << PHT_IDX_BITS;
  localparam int BTB_N     = 1 << BTB_IDX_BITS;
  localparam int TAG_W     = PC_WIDTH - 1 - BTB_IDX_BITS;

  localparam logic [CTR_BITS-1:0]  CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1);
  localparam logic [INIT_BITS-1:0] PTR_ONE  = INIT_BITS'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Saturating up/down counter step.
  function automatic logic [CTR_BITS-1:0] ctr_sat(input logic [CTR_BITS-1:0] c,
                                                 input logic               up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_ONE;
    else    return (c == '0)      ? c : c - CTR_ONE;
  endfunction

  // Shift a new outcome into the youngest history bit; the truncating cast
  // also covers the single-bit history case.
  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] g,
                                                   input logic                b);
    return GHR_BITS'({g, b});
  endfunction

  function automatic logic [PHT_IDX_BITS-1:0] pht_index(input logic [PC_WIDTH-1:0] pc,
                                                       input logic [GHR_BITS-1:0] g);
    return pc[PHT_IDX_BITS:1] ^ PHT_IDX_BITS'(g);
  endfunction

  function automatic logic [BTB_IDX_BITS-1:0] btb_index(input logic [PC_WIDTH-1:0] pc);
    return pc[BTB_IDX_BITS:1];
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(input logic [PC_WIDTH-1:0] pc);
    return pc[PC_WIDTH-1:BTB_IDX_BITS+1];
  endfunction

  state_e                 state_q;
  logic [INIT_BITS-1:0]   init_ptr_q;
  logic [GHR_BITS-1:0]    ghr_q, ghr_d;
  logic                   ready_q;
  logic                   pred_valid_q, pred_taken_q;
  logic [PC_WIDTH-1:0]    pred_target_q;
  logic [GHR_BITS-1:0]    pred_ghr_q;

  logic [CTR_BITS-1:0]    pht_q        [PHT_N];
  logic                   btb_valid_q  [BTB_N];
  logic [TAG_W-1:0]       btb_tag_q    [BTB_N];
  logic [PC_WIDTH-1:0]    btb_target_q [BTB_N];
  logic                   btb_uncond_q [BTB_N];

  // PC bit 0 is always zero for LC-3b and is never used for indexing.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

  logic                    lookup_acc, upd_run;
  logic [PHT_IDX_BITS-1:0] lk_pht_idx, up_pht_idx;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx, up_btb_idx;
  logic                    lk_hit, lk_taken;

  assign lookup_acc = (state_q == ST_RUN) && lookup_valid && !lookup_stall;
  assign upd_run    = (state_q == ST_RUN) && upd_valid;

  assign lk_pht_idx = pht_index(lookup_pc, ghr_q);
  assign lk_btb_idx = btb_index(lookup_pc);
  assign up_pht_idx = pht_index(upd_pc, upd_ghr);
  assign up_btb_idx = btb_index(upd_pc);

  // Arrays are read combinationally here and written at the clock edge, so a
  // same-cycle update to the same entry is not visible to this lookup.
  assign lk_hit   = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == btb_tag(lookup_pc));
  assign lk_taken = lk_hit && (btb_uncond_q[lk_btb_idx] || pht_q[lk_pht_idx][CTR_BITS-1]);

  // Mispredict recovery overrides the speculative shift of a same-cycle lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_run && upd_mispredict) ghr_d = ghr_shift(upd_ghr, upd_taken);
    else if (lookup_acc)           ghr_d = ghr_shift(ghr_q, lk_taken);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      ghr_q         <= '0;
      ready_q       <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + PTR_ONE;
          if (init_ptr_q == '1) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: ;
      endcase
      ghr_q         <= ghr_d;
      pred_valid_q  <= lookup_acc;
      pred_taken_q  <= lookup_acc && lk_taken;
      pred_target_q <= (lookup_acc && lk_taken) ? btb_target_q[lk_btb_idx] : '0;
      if (lookup_acc) pred_ghr_q <= ghr_q;
    end
  end

  // Storage has no reset; the init walk is what puts it in a known state.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      if (32'(init_ptr_q) < PHT_N) pht_q[init_ptr_q[PHT_IDX_BITS-1:0]] <= CTR_WNT;
      if (32'(init_ptr_q) < BTB_N) btb_valid_q[init_ptr_q[BTB_IDX_BITS-1:0]] <= 1'b0;
    end else if (upd_valid) begin
      if (!upd_uncond) pht_q[up_pht_idx] <= ctr_sat(pht_q[up_pht_idx], upd_taken);
      if (upd_taken) begin
        btb_valid_q[up_btb_idx]  <= 1'b1;
        btb_tag_q[up_btb_idx]    <= btb_tag(upd_pc);
        btb_target_q[up_btb_idx] <= upd_target;
        btb_uncond_q[up_btb_idx] <= upd_uncond;
      end
    end
  end

  assign ready       = ready_q;
  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_ghr    = pred_ghr_q;

endmodule
